// File: rtl/sha3_pad.sv
// SHA3-256 message padder: packs bytes into 64-bit lanes and emits 25-lane blocks.
// Optional SHA3_PAD_KECCAK_LEGACY_EN selects the original Keccak 0x01 pad byte.
module sha3_pad (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  output logic        stopin,
  input  logic        firstin,
  input  logic        lastin,
  input  logic [7:0]  din,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic        lastout,
  output logic [63:0] dout
);

`ifdef SHA3_PAD_KECCAK_LEGACY_EN
  localparam logic [7:0] PAD1 = 8'h01;
`else
  localparam logic [7:0] PAD1 = 8'h06;
`endif

  typedef enum logic [1:0] {
    IDLE, ABSORB, PAD, CAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_bcnt;
  logic [4:0]  r_lcnt;
  logic [63:0] r_lane;
  logic [63:0] r_dout;
  logic        r_pushout;
  logic        r_firstout;
  logic        r_lastout;
  logic        r_first;
  logic        r_pad1;
  logic        r_done;
  logic        r_padfull;

  logic        w_acc;
  logic        w_slot;
  logic        w_we;
  logic        w_emit;
  logic        w_b135;
  logic        w_lane_done;
  logic        w_cap_end;
  logic [7:0]  w_byte;
  logic [7:0]  w_padb;
  logic [63:0] w_lane_next;

  assign w_acc       = pushin && !stopin;
  assign w_slot      = !r_pushout || !stopout;
  assign w_b135      = (r_lcnt == 5'd16) && (r_bcnt == 3'd7);
  assign w_lane_done = w_we && (r_bcnt == 3'd7);
  assign w_cap_end   = w_emit && (r_lcnt == 5'd24);
  assign w_padb      = (r_pad1 ? PAD1 : 8'h00)
                     | (w_b135 ? 8'h80 : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_we) w_next = lastin ? PAD : ABSORB;
      end
      ABSORB: begin
        if (w_we) begin
          if (w_b135)      w_next = CAP;
          else if (lastin) w_next = PAD;
        end
      end
      PAD: begin
        if (w_we && w_b135) w_next = CAP;
      end
      CAP: begin
        if (w_cap_end) begin
          if (r_done)         w_next = IDLE;
          else if (r_padfull) w_next = PAD;
          else                w_next = ABSORB;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stopin = r_pushout;
    w_we   = 1'b0;
    w_emit = 1'b0;
    w_byte = din;
    unique case (r_state)
      IDLE:   w_we = w_acc && firstin;
      ABSORB: w_we = w_acc;
      PAD: begin
        stopin = 1'b1;
        w_we   = w_slot;
        w_byte = w_padb;
      end
      CAP: begin
        stopin = 1'b1;
        w_emit = w_slot;
      end
      default: stopin = 1'b1;
    endcase
  end

  always_comb begin
    w_lane_next = r_lane;
    w_lane_next[{r_bcnt, 3'b000} +: 8] = w_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt     <= 3'd0;
      r_lcnt     <= 5'd0;
      r_lane     <= 64'd0;
      r_dout     <= 64'd0;
      r_pushout  <= 1'b0;
      r_firstout <= 1'b0;
      r_lastout  <= 1'b0;
      r_first    <= 1'b0;
      r_pad1     <= 1'b0;
      r_done     <= 1'b0;
      r_padfull  <= 1'b0;
    end else begin
      if (w_we) begin
        r_bcnt <= r_bcnt + 3'd1;
        if (r_bcnt == 3'd7) r_lcnt <= r_lcnt + 5'd1;
      end else if (w_emit) begin
        r_lcnt <= (r_lcnt == 5'd24) ? 5'd0 : r_lcnt + 5'd1;
      end

      // A completed lane goes straight to the output register.
      if (w_lane_done) begin
        r_dout     <= w_lane_next;
        r_pushout  <= 1'b1;
        r_firstout <= r_first && (r_lcnt == 5'd0);
        r_lastout  <= 1'b0;
        r_lane     <= 64'd0;
        r_first    <= 1'b0;
      end else begin
        if (w_we) r_lane <= w_lane_next;
        if (w_emit) begin
          r_dout     <= 64'd0;
          r_pushout  <= 1'b1;
          r_firstout <= 1'b0;
          r_lastout  <= (r_lcnt == 5'd24) && r_done;
        end else if (r_pushout && !stopout) begin
          r_pushout  <= 1'b0;
          r_firstout <= 1'b0;
          r_lastout  <= 1'b0;
        end
      end

      if (r_state == IDLE && w_we) r_first <= 1'b1;

      if (r_state != PAD) r_pad1 <= 1'b1;
      else if (w_we)      r_pad1 <= 1'b0;

      if (r_state == IDLE)                    r_done <= 1'b0;
      else if (r_state == PAD && w_we && w_b135) r_done <= 1'b1;

      if (r_state == ABSORB && w_we && lastin && w_b135)
        r_padfull <= 1'b1;
      else if (w_cap_end)
        r_padfull <= 1'b0;
    end
  end

  assign pushout  = r_pushout;
  assign firstout = r_firstout;
  assign lastout  = r_lastout;
  assign dout     = r_dout;

endmodule
